// File: rtl/enc_velocity_pkg.sv
// enc_velocity_pkg: shared encoder FSM states and saturation limit helpers
package enc_velocity_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  function automatic logic [63:0] sat_hi(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_lo(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/enc_velocity_if.sv
// enc_velocity_if: count/control inputs and velocity result bundle
interface enc_velocity_if #(
  parameter int ENCBITS = 64,
  parameter int VELBITS = 32,
  parameter int WINBITS = 24
);
  logic signed [ENCBITS-1:0] count;
  logic faultn;
  logic enable;
  logic [WINBITS-1:0] window;
  logic signed [VELBITS-1:0] velocity;
  logic vel_valid;
  logic vel_sat;
  logic vel_fault;
  modport master (output count, faultn, enable, window, input velocity, vel_valid, vel_sat, vel_fault);
  modport slave (input count, faultn, enable, window, output velocity, vel_valid, vel_sat, vel_fault);
endinterface

// File: rtl/enc_velocity_sat.sv
// sat_signed: clamp a wide signed value into a narrower signed range
module sat_signed
  import enc_velocity_pkg::*;
#(
  parameter int ENCBITS = 64,
  parameter int VELBITS = 32
) (
  input  logic signed [ENCBITS-1:0] d_i,
  output logic signed [VELBITS-1:0] q_o,
  output logic sat_o
);
  localparam logic [VELBITS-1:0] VMAX = VELBITS'(sat_hi(VELBITS));
  localparam logic [VELBITS-1:0] VMIN = VELBITS'(sat_lo(VELBITS));
  logic [ENCBITS-VELBITS:0] top;
  assign top = d_i[ENCBITS-1:VELBITS-1];
  // value fits only when all bits above the output sign bit match it
  always_comb begin
    sat_o = !(&top || ~|top);
    q_o = sat_o ? (d_i[ENCBITS-1] ? VMIN : VMAX) : d_i[VELBITS-1:0];
  end
endmodule

// File: rtl/enc_velocity.sv
// enc_velocity: windowed encoder count differencing into saturated velocity
module enc_velocity
  import enc_velocity_pkg::*;
#(
  parameter int ENCBITS = 64,
  parameter int VELBITS = 32,
  parameter int WINBITS = 24
) (
  input logic clk,
  input logic reset,
  enc_velocity_if.slave bus
);
  state_t state_q, state_d;
  logic signed [ENCBITS-1:0] prev_q, prev_d, delta;
  logic [WINBITS-1:0] timer_q, timer_d;
  logic signed [VELBITS-1:0] vel_q, vel_d, vel_w;
  logic facc_q, facc_d, valid_q, valid_d, sat_q, sat_d, flt_q, flt_d, sat_w, expire;
  assign delta = bus.count - prev_q;
  assign expire = (state_q == RUN) && (timer_q == '0);
  sat_signed #(.ENCBITS(ENCBITS), .VELBITS(VELBITS)) u_sat (.d_i(delta), .q_o(vel_w), .sat_o(sat_w));
  assign bus.velocity = vel_q;
  assign bus.vel_valid = valid_q;
  assign bus.vel_sat = sat_q;
  assign bus.vel_fault = flt_q;
  // next state: prime on entry, count down, sample and reload on expiry
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    timer_d = timer_q;
    facc_d = facc_q;
    vel_d = vel_q;
    valid_d = 1'b0;
    sat_d = sat_q;
    flt_d = flt_q;
    case (state_q)
      IDLE: state_d = (bus.enable && bus.window != '0) ? PRIME : IDLE;
      PRIME: begin
        prev_d = bus.count;
        timer_d = bus.window - 1'b1;
        facc_d = !bus.faultn;
        state_d = (bus.window != '0) ? RUN : IDLE;
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (expire) begin
          vel_d = vel_w;
          sat_d = sat_w;
          flt_d = facc_q || !bus.faultn;
          valid_d = 1'b1;
          facc_d = 1'b0;
          prev_d = bus.count;
          timer_d = bus.window - 1'b1;
          state_d = (bus.window != '0) ? RUN : IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
          facc_d = facc_q || !bus.faultn;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q <= '0;
      timer_q <= '0;
      facc_q <= 1'b0;
      vel_q <= '0;
      valid_q <= 1'b0;
      sat_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= prev_d;
      timer_q <= timer_d;
      facc_q <= facc_d;
      vel_q <= vel_d;
      valid_q <= valid_d;
      sat_q <= sat_d;
      flt_q <= flt_d;
    end
  end
endmodule

// File: tb/tb_enc_velocity.sv
// tb_enc_velocity: directed checks of windowed velocity, saturation, faults and control
module tb_enc_velocity;
  import enc_velocity_pkg::*;
  logic clk = 1'b0;
  logic reset, rst_b;
  int total = 0, bad = 0, cyc = 0, npulse = 0, last_at = 0;
  logic signed [63:0] step;
  logic [31:0] pv;
  logic ps, pf;
  enc_velocity_if bus_a ();
  enc_velocity_if #(.VELBITS(8)) bus_b ();
  enc_velocity dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  enc_velocity #(.VELBITS(8)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus_a.vel_valid) begin
      npulse++;
      last_at = cyc;
      pv = bus_a.velocity;
      ps = bus_a.vel_sat;
      pf = bus_a.vel_fault;
    end
    bus_a.count = bus_a.count + step;
  endtask
  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask
  initial begin
    reset = 1'b1;
    rst_b = 1'b1;
    step = '0;
    pv = '0;
    ps = 1'b0;
    pf = 1'b0;
    bus_a.count = '0;
    bus_a.faultn = 1'b1;
    bus_a.enable = 1'b0;
    bus_a.window = '0;
    bus_b.count = '0;
    bus_b.faultn = 1'b1;
    bus_b.enable = 1'b0;
    bus_b.window = '0;
    tick();
    tick();
    check("rst_vel", 64'(bus_a.velocity), 64'd0);
    check("rst_valid", 64'(bus_a.vel_valid), 64'd0);
    check("rst_sat", 64'(bus_a.vel_sat), 64'd0);
    check("rst_fault", 64'(bus_a.vel_fault), 64'd0);
    check("rst_state", 64'(dut_a.state_q), 64'(IDLE));
    reset = 1'b0;
    rst_b = 1'b0;
    bus_b.enable = 1'b1;
    bus_b.window = 24'd2;
    tick();
    tick();
    bus_b.count = 64'sd300;
    tick();
    check("b_early", 64'(bus_b.vel_valid), 64'd0);
    tick();
    check("b_pos_valid", 64'(bus_b.vel_valid), 64'd1);
    check("b_pos_vel", {56'd0, bus_b.velocity}, 64'h7f);
    check("b_pos_sat", 64'(bus_b.vel_sat), 64'd1);
    bus_b.count = '0;
    tick();
    check("b_hold", {56'd0, bus_b.velocity}, 64'h7f);
    tick();
    check("b_neg_vel", {56'd0, bus_b.velocity}, 64'h80);
    check("b_neg_sat", 64'(bus_b.vel_sat), 64'd1);
    bus_b.count = 64'sd100;
    tick();
    tick();
    check("b_mid_valid", 64'(bus_b.vel_valid), 64'd1);
    check("b_mid_vel", {56'd0, bus_b.velocity}, 64'd100);
    check("b_mid_sat", 64'(bus_b.vel_sat), 64'd0);
    bus_b.enable = 1'b0;
    cyc = 0;
    npulse = 0;
    step = 64'sd3;
    bus_a.count = '0;
    bus_a.window = 24'd10;
    bus_a.enable = 1'b1;
    run_to(11);
    check("ramp_none", 64'(npulse), 64'd0);
    tick();
    check("ramp_first_at", 64'(last_at), 64'd12);
    check("ramp_vel", 64'(pv), 64'd30);
    check("ramp_sat", 64'(ps), 64'd0);
    check("ramp_fault", 64'(pf), 64'd0);
    run_to(22);
    check("ramp_n2", 64'(npulse), 64'd2);
    check("ramp_at2", 64'(last_at), 64'd22);
    check("ramp_vel2", 64'(pv), 64'd30);
    tick();
    check("hold_valid", 64'(bus_a.vel_valid), 64'd0);
    check("hold_vel", 64'(bus_a.velocity), 64'd30);
    run_to(26);
    bus_a.faultn = 1'b0;
    tick();
    bus_a.faultn = 1'b1;
    run_to(32);
    check("flt_at", 64'(last_at), 64'd32);
    check("flt_set", 64'(pf), 64'd1);
    check("flt_vel", 64'(pv), 64'd30);
    run_to(42);
    check("flt_clr_at", 64'(last_at), 64'd42);
    check("flt_clr", 64'(pf), 64'd0);
    run_to(47);
    bus_a.enable = 1'b0;
    run_to(50);
    check("dis_n", 64'(npulse), 64'd4);
    check("dis_vel", 64'(bus_a.velocity), 64'd30);
    check("dis_state", 64'(dut_a.state_q), 64'(IDLE));
    bus_a.enable = 1'b1;
    step = 64'sd5;
    run_to(61);
    check("reen_none", 64'(npulse), 64'd4);
    tick();
    check("reen_at", 64'(last_at), 64'd62);
    check("reen_vel", 64'(pv), 64'd50);
    run_to(71);
    bus_a.window = '0;
    tick();
    check("w0_at", 64'(last_at), 64'd72);
    check("w0_vel", 64'(pv), 64'd50);
    run_to(90);
    check("w0_n", 64'(npulse), 64'd6);
    check("w0_state", 64'(dut_a.state_q), 64'(IDLE));
    step = '0;
    bus_a.count = 64'h7fff_ffff_ffff_fffb;
    bus_a.window = 24'd4;
    run_to(93);
    bus_a.count = 64'h8000_0000_0000_0004;
    run_to(96);
    check("wrap_at", 64'(last_at), 64'd96);
    check("wrap_vel", 64'(pv), 64'd9);
    check("wrap_sat", 64'(ps), 64'd0);
    run_to(97);
    bus_a.count = bus_a.count + 64'sh100_0000_0000;
    run_to(100);
    check("big_at", 64'(last_at), 64'd100);
    check("big_vel", 64'(pv), 64'h7fff_ffff);
    check("big_sat", 64'(ps), 64'd1);
    run_to(101);
    bus_a.count = bus_a.count + 64'sd55;
    run_to(104);
    check("v55_vel", 64'(pv), 64'd55);
    check("v55_sat", 64'(ps), 64'd0);
    run_to(106);
    reset = 1'b1;
    tick();
    check("mrst_vel", 64'(bus_a.velocity), 64'd0);
    check("mrst_valid", 64'(bus_a.vel_valid), 64'd0);
    check("mrst_sat", 64'(bus_a.vel_sat), 64'd0);
    check("mrst_state", 64'(dut_a.state_q), 64'(IDLE));
    run_to(108);
    reset = 1'b0;
    tick();
    check("rel_valid", 64'(bus_a.vel_valid), 64'd0);
    run_to(113);
    check("rel_n", 64'(npulse), 64'd9);
    run_to(114);
    check("rel_at", 64'(last_at), 64'd114);
    check("rel_vel", 64'(pv), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enc_velocity.md
ENC_VELOCITY -- requirements
Module: enc_velocity

Interface
REQ-001 SHALL have parameter ENCBITS, default 64, width of the signed encoder count consumed.
REQ-002 SHALL have parameter VELBITS, default 32, width of the signed velocity output.
REQ-003 SHALL have parameter WINBITS, default 24, width of the sample-window length.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 count  input  ENCBITS signed  position count from the quadrature counter stage.
REQ-007 faultn  input  1  counter fault flag, active-low (both phases stepped in one clock).
REQ-008 enable  input  1  run velocity sampling when high.
REQ-009 window  input  WINBITS  clocks per velocity sample; 0 = invalid.
REQ-010 velocity  output  VELBITS signed  counts per window, saturated.
REQ-011 vel_valid  output  1  one-clock pulse when velocity updates.
REQ-012 vel_sat  output  1  last sample was clamped; qualified by vel_valid.
REQ-013 vel_fault  output  1  faultn was low at any clock of the last window; qualified by vel_valid.

Function
REQ-014 SHALL implement states IDLE, PRIME, RUN.
REQ-015 IDLE: enable=1 and window!=0 -> PRIME; otherwise stay; no vel_valid.
REQ-016 PRIME (one clock): prev <= count, timer <= window-1, fault accumulator cleared -> RUN.
REQ-017 RUN: timer decrements by 1 each clock; at timer==0 the expiry clock samples count.
REQ-018 On expiry: delta = count - prev modulo 2^ENCBITS (wrap-correct across counter rollover); prev <= count; timer <= window-1 with window resampled at that clock.
REQ-019 Window length SHALL equal exactly window clocks between consecutive count samples.
REQ-020 velocity, vel_sat, vel_fault SHALL be registered and vel_valid asserted on the clock after expiry (latency 1).
REQ-021 delta > 2^(VELBITS-1)-1 SHALL yield max positive, delta < -2^(VELBITS-1) max negative, vel_sat=1; else vel_sat=0.
REQ-022 faultn low on any clock from PRIME through expiry inclusive SHALL set vel_fault for that sample; velocity still updates; accumulator clears after expiry.
REQ-023 If window==0 at an expiry resample, SHALL go to IDLE after emitting the current sample.
REQ-024 enable deasserted in RUN SHALL go to IDLE next clock, discard the partial window, no vel_valid; velocity holds.
REQ-025 Re-enable SHALL always pass through PRIME (first window never spans an idle gap).
REQ-026 velocity, vel_sat, vel_fault SHALL hold between vel_valid pulses.

Reset
REQ-027 reset high SHALL, at the next clock edge, force IDLE, velocity=0, vel_valid=0, vel_sat=0, vel_fault=0, prev=0, timer=0, regardless of state.
REQ-028 reset SHALL override enable; no vel_valid on the clock reset deasserts.

Structure
REQ-029 State encodings and saturation limit constants SHALL live in the shared encoder constants package/header used by the encoder blocks.
REQ-030 Saturation SHALL be a sub-module sat_signed (ENCBITS in, VELBITS out, sat flag), combinational.
REQ-031 Implementation target 120-400 lines RTL; no multipliers or dividers.

Verification
REQ-032 window=10, count ramps +3/clk, enable -> first vel_valid 12 clocks after enable, velocity=30, repeating every 10 clocks.
REQ-033 count steps from 2^63-5 to -2^63+4 (ENCBITS=64) within one window -> velocity=+9, vel_sat=0.
REQ-034 VELBITS=8, delta +300 -> velocity=127, vel_sat=1; delta -300 -> velocity=-128, vel_sat=1.
REQ-035 faultn low one clock mid-window -> that sample vel_fault=1, next sample vel_fault=0.
REQ-036 enable dropped at timer=4, reasserted 3 clocks later -> no pulse for partial window; next pulse after PRIME+window, delta from re-prime count.
REQ-037 reset asserted mid-RUN with velocity=55 -> next clock velocity=0, vel_valid=0, state IDLE.
